// File: rtl/life_gen_engine_if.sv
// Control, read-port and status bundle between the Game-of-Life engine and its host/renderer.
// master drives controls and the read address; slave is the engine.
interface life_gen_engine_if #(
    parameter int AW   = 6,
    parameter int SIZE = 64
);
    logic            frame_tick;
    logic            run;
    logic            step;
    logic            clear;
    logic [AW-1:0]   rd_addr;
    logic            rd_data;
    logic [SIZE-1:0] board_o;
    logic            busy;
    logic            gen_done;
    logic [15:0]     gen_count;

    modport master (
        output frame_tick, run, step, clear, rd_addr,
        input  rd_data, board_o, busy, gen_done, gen_count
    );

    modport slave (
        input  frame_tick, run, step, clear, rd_addr,
        output rd_data, board_o, busy, gen_done, gen_count
    );
endinterface

// File: rtl/life_gen_engine.sv
// Serial Game-of-Life engine: one cell per clock into a scratch board, committed in a single cycle
// so the displayed board never tears. Dead (non-wrapping) borders.
module life_gen_engine #(
    parameter int BIT_WIDTH      = 3,
    parameter int BIT_HEIGHT     = 3,
    parameter int FRAMES_PER_GEN = 60,
    parameter logic [(1<<(BIT_WIDTH+BIT_HEIGHT))-1:0] SEED = 64'h0000_0000_0007_0402
) (
    input  logic clk,
    input  logic reset,
    life_gen_engine_if.slave bus
);
    localparam int W    = 1 << BIT_WIDTH;
    localparam int H    = 1 << BIT_HEIGHT;
    localparam int AW   = BIT_WIDTH + BIT_HEIGHT;
    localparam int SIZE = 1 << AW;
    localparam logic [5:0] FDIV_LAST = 6'(FRAMES_PER_GEN - 1);

    typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

    state_t            state_q, state_d;
    logic [SIZE-1:0]   cur_q, cur_d, nxt_q, nxt_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [5:0]        fdiv_q, fdiv_d;
    logic [15:0]       gen_count_q, gen_count_d;
    logic              gen_done_q, gen_done_d;
    logic              auto_trig;
    logic [BIT_HEIGHT-1:0] row;
    logic [BIT_WIDTH-1:0]  col;
    logic [3:0]        n;
    logic              live;
    int                nr, nc;

    // Neighbour count for the cell under the scan pointer; off-grid cells are skipped, never wrapped.
    always_comb begin
        row = idx_q[AW-1:BIT_WIDTH];
        col = idx_q[BIT_WIDTH-1:0];
        n   = '0;
        nr  = 0;
        nc  = 0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                nr = int'(row) + dr;
                nc = int'(col) + dc;
                if (!(dr == 0 && dc == 0) && nr >= 0 && nr < H && nc >= 0 && nc < W)
                    n = n + 4'(cur_q[AW'(nr * W + nc)]);
            end
        end
        live = (n == 4'd3) | (cur_q[idx_q] & (n == 4'd2));
    end

    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        nxt_d       = nxt_q;
        idx_d       = idx_q;
        fdiv_d      = fdiv_q;
        gen_count_d = gen_count_q;
        gen_done_d  = 1'b0;
        auto_trig   = 1'b0;

        // The divider keeps running while busy, so a tick landing mid-generation is simply lost.
        if (bus.frame_tick && bus.run) begin
            if (fdiv_q == FDIV_LAST) begin
                fdiv_d    = '0;
                auto_trig = 1'b1;
            end else begin
                fdiv_d = fdiv_q + 6'd1;
            end
        end

        case (state_q)
            IDLE: begin
                if (auto_trig || bus.step) begin
                    state_d = SCAN;
                    idx_d   = '0;
                end
            end
            SCAN: begin
                nxt_d[idx_q] = live;
                if (idx_q == '1) state_d = COMMIT;
                else             idx_d   = idx_q + 1'b1;
            end
            COMMIT: begin
                cur_d       = nxt_q;
                gen_count_d = gen_count_q + 16'd1;
                gen_done_d  = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (bus.clear) begin
            state_d     = IDLE;
            cur_d       = SEED;
            nxt_d       = '0;
            idx_d       = '0;
            fdiv_d      = '0;
            gen_count_d = '0;
            gen_done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cur_q       <= SEED;
            nxt_q       <= '0;
            idx_q       <= '0;
            fdiv_q      <= '0;
            gen_count_q <= '0;
            gen_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            nxt_q       <= nxt_d;
            idx_q       <= idx_d;
            fdiv_q      <= fdiv_d;
            gen_count_q <= gen_count_d;
            gen_done_q  <= gen_done_d;
        end
    end

    assign bus.rd_data   = cur_q[bus.rd_addr];
    assign bus.board_o   = cur_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.gen_done  = gen_done_q;
    assign bus.gen_count = gen_count_q;
endmodule

// File: tb/tb_life_gen_engine.sv
// Directed bench: three engines with different seeds (glider, blinker, corner L) on a shared clock.
module tb_life_gen_engine;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    life_gen_engine_if #(.AW(6), .SIZE(64)) b0 ();
    life_gen_engine_if #(.AW(6), .SIZE(64)) b1 ();
    life_gen_engine_if #(.AW(6), .SIZE(64)) b2 ();

    life_gen_engine u0 (.clk(clk), .reset(reset), .bus(b0));
    life_gen_engine #(.SEED(64'h0000_0000_1C00_0000)) u1 (.clk(clk), .reset(reset), .bus(b1));
    life_gen_engine #(.SEED(64'h0000_0000_0000_0103)) u2 (.clk(clk), .reset(reset), .bus(b2));

    int n_chk = 0;
    int n_pass = 0;
    int busy_cyc, gd, e, t;
    int gd_edge[2];
    int tick_edge[2];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic nxt_cyc();
        @(posedge clk);
        #1;
    endtask

    // Drive nticks frame_ticks (one every 3 cycles) on u0 and record gen_done timing.
    task automatic tick_run(input int nticks, input int ncyc);
        gd = 0; e = 0; t = 0;
        gd_edge[0] = 0; gd_edge[1] = 0; tick_edge[0] = 0; tick_edge[1] = 0;
        for (int c = 0; c < ncyc; c++) begin
            if (b0.gen_done) begin
                if (gd < 2) gd_edge[gd] = e;
                gd++;
            end
            b0.frame_tick = (c % 3 == 0) && (t < nticks);
            if (b0.frame_tick) begin
                t++;
                if (t == 60)  tick_edge[0] = e + 1;
                if (t == 120) tick_edge[1] = e + 1;
            end
            nxt_cyc();
            e++;
        end
        b0.frame_tick = 1'b0;
    endtask

    initial begin
        {b0.frame_tick, b0.run, b0.step, b0.clear} = '0;
        {b1.frame_tick, b1.run, b1.step, b1.clear} = '0;
        {b2.frame_tick, b2.run, b2.step, b2.clear} = '0;
        b0.rd_addr = '0; b1.rd_addr = '0; b2.rd_addr = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // reset state
        chk("rst_board", b0.board_o, 64'h70402);
        chk("rst_busy", 64'(b0.busy), 64'd0);
        chk("rst_gcnt", 64'(b0.gen_count), 64'd0);
        b0.rd_addr = 6'd1; #1;
        chk("rst_rd1", 64'(b0.rd_data), 64'd1);
        b0.rd_addr = 6'd0; #1;
        chk("rst_rd0", 64'(b0.rd_data), 64'd0);

        // blinker, first step
        b1.step = 1'b1; nxt_cyc(); b1.step = 1'b0;
        busy_cyc = 0; gd = 0;
        for (int i = 0; i < 90; i++) begin
            if (b1.busy) busy_cyc++;
            if (b1.gen_done) gd++;
            if (i == 30) chk("blk_stable", b1.board_o, 64'h1C00_0000);
            nxt_cyc();
        end
        chk("blk1_busy", 64'(busy_cyc), 64'd65);
        chk("blk1_gdone", 64'(gd), 64'd1);
        chk("blk1_board", b1.board_o, 64'h0000_0008_0808_0000);
        chk("blk1_gcnt", 64'(b1.gen_count), 64'd1);

        // blinker, second step; a step raised mid-scan must be dropped
        b1.step = 1'b1; nxt_cyc(); b1.step = 1'b0;
        busy_cyc = 0; gd = 0;
        for (int i = 0; i < 150; i++) begin
            if (b1.busy) busy_cyc++;
            if (b1.gen_done) gd++;
            b1.step = (i == 20);
            nxt_cyc();
        end
        b1.step = 1'b0;
        chk("blk2_busy", 64'(busy_cyc), 64'd65);
        chk("blk2_gdone", 64'(gd), 64'd1);
        chk("blk2_board", b1.board_o, 64'h1C00_0000);
        chk("blk2_gcnt", 64'(b1.gen_count), 64'd2);

        // corner L: grid edges must not wrap
        b2.step = 1'b1; nxt_cyc(); b2.step = 1'b0;
        repeat (70) nxt_cyc();
        chk("L_board", b2.board_o, 64'h0303);
        chk("L_gcnt", 64'(b2.gen_count), 64'd1);
        foreach (gd_edge[k]) gd_edge[k] = 0;
        b2.rd_addr = 6'd7;  #1; chk("L_bit7", 64'(b2.rd_data), 64'd0);
        b2.rd_addr = 6'd15; #1; chk("L_bit15", 64'(b2.rd_data), 64'd0);
        b2.rd_addr = 6'd56; #1; chk("L_bit56", 64'(b2.rd_data), 64'd0);
        b2.rd_addr = 6'd63; #1; chk("L_bit63", 64'(b2.rd_data), 64'd0);
        b2.rd_addr = 6'd9;  #1; chk("L_bit9", 64'(b2.rd_data), 64'd1);

        // auto-run: ticks with run=0 must not advance the divider
        b0.run = 1'b0;
        tick_run(30, 100);
        chk("run0_gdone", 64'(gd), 64'd0);
        b0.run = 1'b1;
        tick_run(120, 450);
        b0.run = 1'b0;
        chk("run_gdone", 64'(gd), 64'd2);
        chk("run_lat60", 64'(gd_edge[0] - tick_edge[0]), 64'd65);
        chk("run_lat120", 64'(gd_edge[1] - tick_edge[1]), 64'd65);
        chk("run_gcnt", 64'(b0.gen_count), 64'd2);

        // clear mid-scan on the L engine (board 0x303, count 1)
        b2.step = 1'b1; nxt_cyc(); b2.step = 1'b0;
        gd = 0; busy_cyc = 0;
        for (int i = 0; i < 31; i++) begin
            if (i == 30) chk("clr_stable", b2.board_o, 64'h0303);
            b2.clear = (i == 30);
            nxt_cyc();
        end
        b2.clear = 1'b0;
        chk("clr_busy", 64'(b2.busy), 64'd0);
        chk("clr_board", b2.board_o, 64'h0103);
        chk("clr_gcnt", 64'(b2.gen_count), 64'd0);
        for (int i = 0; i < 80; i++) begin
            if (b2.busy) busy_cyc++;
            if (b2.gen_done) gd++;
            nxt_cyc();
        end
        chk("clr_no_gdone", 64'(gd), 64'd0);
        chk("clr_idle", 64'(busy_cyc), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
